// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB completer among NUM_REQ requesters,
// with a PREADY watchdog so a hung completer cannot stall the bus.
package apb_pkg;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;
endpackage

// state  | meaning
// IDLE   | arbitrate, accept one request, deliver previous completion
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or watchdog abort
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic                          busy,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_WIDTH-1:0]         prdata
);

    localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    apb_state_t             state_q, state_d;
    logic [GW-1:0]          last_grant_q;
    logic [GW-1:0]          owner_q;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic                   pwrite_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic [CW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   busy_q;

    logic [GW-1:0]          grant_idx;
    logic                   grant_vld;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_write;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   accept;
    logic                   tmo_hit;
    logic                   done;

    // Lowest index above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (GW'(i) <= last_grant_q)) begin
                grant_idx = GW'(i);
                grant_vld = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (GW'(i) > last_grant_q)) begin
                grant_idx = GW'(i);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept  = (state_q == IDLE) && grant_vld;
    assign tmo_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready &&
                     (tmo_cnt_q == CW'(TMO_LAST));
    assign done    = (state_q == ACCESS) && (pready || tmo_hit);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = grant_vld && (grant_idx == GW'(i));
                end
            end
            SETUP: psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Completion data; the watchdog abort reports an error with zero data.
    always_comb begin
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        tmo_cnt_d    = '0;
        if (state_q == ACCESS) begin
            if (pready) begin
                rsp_rdata_d  = pwrite_q ? '0 : prdata;
                rsp_slverr_d = pslverr;
            end else if (tmo_hit) begin
                rsp_rdata_d  = '0;
                rsp_slverr_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
        if (done) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (owner_q == GW'(i));
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            owner_q      <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            tmo_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            tmo_cnt_q    <= tmo_cnt_d;
            busy_q       <= (state_d != IDLE);
            if (accept) begin
                paddr_q      <= sel_addr;
                pwrite_q     <= sel_write;
                pwdata_q     <= sel_wdata;
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed scenarios plus a randomized
// run against a transaction-level round-robin/APB reference model.
module tb_apb_rr_master;
    import apb_pkg::*;

    localparam int NR  = 2;
    localparam int TMO = 16;

    logic                     pclk = 1'b0;
    logic                     preset = 1'b1;
    logic [NR-1:0]            req_valid, req_ready, req_write, rsp_valid;
    logic [NR*ADDR_WIDTH-1:0] req_addr;
    logic [NR*DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0]    rsp_rdata, pwdata, prdata;
    logic [ADDR_WIDTH-1:0]    paddr;
    logic                     rsp_slverr, busy, psel, penable, pwrite, pready, pslverr;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb_rr_master #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({psel, penable, pwrite, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {psel, penable, pwrite, busy});
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0) begin
            errors++; $display("FAIL reset_bus: got paddr=%h pwdata=%h expected 0", paddr, pwdata);
        end
        checks++;
        if (rsp_valid !== '0 || rsp_rdata !== '0 || rsp_slverr !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got %b %h %b expected 0", rsp_valid, rsp_rdata, rsp_slverr);
        end
        preset = 1'b0;
        step();
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready);
        end
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL no_req_ready: got %b expected 00", req_ready);
        end
        step();
    endtask

    task automatic test_single_read();
        int psel_cyc = 0;
        int rsp_at = -1;
        set_req(0, 1'b1, 1'b0, 10'h155, 32'h0);
        prdata = 32'hDEADBEEF; pready = 1'b1; pslverr = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rd_ready: got %b expected 01", req_ready);
        end
        for (int c = 1; c <= 8 && rsp_at < 0; c++) begin
            step();
            req_valid = '0;
            if (psel === 1'b1) psel_cyc++;
            if (c == 1) begin
                checks++;
                if (!(psel === 1'b1 && penable === 1'b0 && paddr === 10'h155 && pwrite === 1'b0 && busy === 1'b1)) begin
                    errors++; $display("FAIL rd_setup: got psel=%b penable=%b paddr=%h pwrite=%b busy=%b expected 1 0 155 0 1",
                                       psel, penable, paddr, pwrite, busy);
                end
            end
            if (rsp_valid !== '0) rsp_at = c;
        end
        checks++;
        if (rsp_at != 3 || psel_cyc != 2) begin
            errors++; $display("FAIL rd_latency: got rsp_cycle=%0d psel_cycles=%0d expected 3 2", rsp_at, psel_cyc);
        end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || rsp_slverr !== 1'b0 || psel !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: got %b %h %b psel=%b expected 01 deadbeef 0 psel=0",
                               rsp_valid, rsp_rdata, rsp_slverr, psel);
        end
        pready = 1'b0;
        prdata = 32'h0;
        step();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_hold: got %b %h expected 00 deadbeef", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_write_wait();
        set_req(1, 1'b1, 1'b1, 10'h3FF, 32'hA5A5A5A5);
        pready = 1'b0; prdata = 32'h11111111;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL wr_ready: got %b expected 10", req_ready);
        end
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (!(psel === 1'b1 && penable === 1'b1 && paddr === 10'h3FF && pwdata === 32'hA5A5A5A5 &&
                  pwrite === 1'b1 && rsp_valid === 2'b00)) begin
                errors++; $display("FAIL wr_access%0d: got psel=%b penable=%b paddr=%h pwdata=%h rsp=%b expected 1 1 3ff a5a5a5a5 00",
                                   k, psel, penable, paddr, pwdata, rsp_valid);
            end
            pready = (k == 3);
        end
        step();
        pready = 1'b0;
        checks++;
        if (psel !== 1'b0 || rsp_valid !== 2'b10 || rsp_rdata !== '0 || rsp_slverr !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: got psel=%b rsp=%b rdata=%h err=%b busy=%b expected 0 10 0 0 0",
                               psel, rsp_valid, rsp_rdata, rsp_slverr, busy);
        end
    endtask

    task automatic test_round_robin();
        int gcyc[$];
        int gidx[$];
        int rown[$];
        set_req(0, 1'b1, 1'b0, 10'h010, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'h020, 32'h0);
        pready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (gidx.size() == 4) req_valid = '0;
            prdata = 32'(c);
            #1;
            if (req_ready === 2'b01) begin gcyc.push_back(c); gidx.push_back(0); end
            if (req_ready === 2'b10) begin gcyc.push_back(c); gidx.push_back(1); end
            step();
            if (rsp_valid === 2'b01) rown.push_back(0);
            if (rsp_valid === 2'b10) rown.push_back(1);
        end
        pready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= gidx.size() || gidx[i] != (i % 2)) begin
                errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, (i < gidx.size()) ? gidx[i] : -1, i % 2);
            end
            checks++;
            if (i >= rown.size() || rown[i] != (i % 2)) begin
                errors++; $display("FAIL rr_rsp_owner%0d: got %0d expected %0d", i, (i < rown.size()) ? rown[i] : -1, i % 2);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (i >= gcyc.size() || gcyc[i] - gcyc[i-1] != 3) begin
                errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", i, (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1);
            end
        end
    endtask

    task automatic test_slave_error();
        bit seen = 0;
        set_req(0, 1'b1, 1'b0, 10'h0AA, 32'h0);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h12345678;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            req_valid = '0;
            if (rsp_valid !== '0) seen = 1;
        end
        checks++;
        if (!seen || rsp_valid !== 2'b01 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h12345678) begin
            errors++; $display("FAIL slverr_rsp: got %b %b %h expected 01 1 12345678", rsp_valid, rsp_slverr, rsp_rdata);
        end
        pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic test_timeout();
        int acc = 0;
        bit seen = 0;
        set_req(1, 1'b1, 1'b0, 10'h077, 32'h0);
        pready = 1'b0; prdata = 32'hFFFF0000;
        for (int c = 0; c < 100 && !seen; c++) begin
            step();
            req_valid = '0;
            if (penable === 1'b1) acc++;
            if (rsp_valid !== '0) seen = 1;
        end
        checks++;
        if (!seen || acc != TMO) begin
            errors++; $display("FAIL tmo_cycles: got %0d access cycles (done=%0d) expected %0d", acc, seen, TMO);
        end
        checks++;
        if (psel !== 1'b0 || rsp_valid !== 2'b10 || rsp_slverr !== 1'b1 || rsp_rdata !== '0) begin
            errors++; $display("FAIL tmo_rsp: got psel=%b rsp=%b err=%b rdata=%h expected 0 10 1 0",
                               psel, rsp_valid, rsp_slverr, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 1'b0, 10'h099, 32'h0);
        pready = 1'b0;
        step();
        req_valid = '0;
        step();
        step();
        checks++;
        if (penable !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_access: got penable=%b expected 1", penable);
        end
        preset = 1'b1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_immediate: got psel=%b penable=%b rsp=%b busy=%b expected 0",
                               psel, penable, rsp_valid, busy);
        end
        step();
        step();
        preset = 1'b0;
        step();
        checks++;
        if (rsp_valid !== '0 || psel !== 1'b0) begin
            errors++; $display("FAIL rstmid_silent: got rsp=%b psel=%b expected 00 0", rsp_valid, psel);
        end
        set_req(0, 1'b1, 1'b0, 10'h1C3, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'h0F0, 32'h0);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rstmid_grant: got %b expected 01", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (paddr !== 10'h1C3) begin
            errors++; $display("FAIL rstmid_paddr: got %h expected 1c3", paddr);
        end
        pready = 1'b1;
        step();
        step();
        pready = 1'b0;
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++; $display("FAIL rstmid_rsp: got %b expected 01", rsp_valid);
        end
    endtask

    // Transaction-level model: pending requests per requester, a round-robin
    // pointer, and the in-flight transfer with its chosen wait states.
    task automatic test_random();
        bit                    pend[NR];
        logic [ADDR_WIDTH-1:0] ra[NR];
        logic                  rw[NR];
        logic [DATA_WIDTH-1:0] rd[NR];
        bit act = 0, ending = 0, rsp_due = 0;
        int age = 0, own = 0, nwait = 0, ptr = NR - 1;
        logic [ADDR_WIDTH-1:0] x_addr = '0;
        logic                  x_wr = 1'b0, x_err = 1'b0, hold_err = 1'b0;
        logic [DATA_WIDTH-1:0] x_wd = '0, x_rd = '0, hold_rd = '0;
        logic [NR-1:0]         exp_rv, exp_ready;
        req_valid = '0; pready = 1'b0;
        preset = 1'b1;
        step();
        step();
        preset = 1'b0;
        for (int i = 0; i < NR; i++) begin pend[i] = 0; ra[i] = '0; rw[i] = 1'b0; rd[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            step();
            if (ending) begin act = 0; ending = 0; end
            else if (act) age++;
            exp_rv = '0;
            if (rsp_due) exp_rv[own] = 1'b1;
            rsp_due = 0;
            checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== hold_rd || rsp_slverr !== hold_err) begin
                errors++; $display("FAIL rnd_rsp c%0d: got %b %h %b expected %b %h %b",
                                   c, rsp_valid, rsp_rdata, rsp_slverr, exp_rv, hold_rd, hold_err);
            end
            checks++;
            if (act) begin
                if (psel !== 1'b1 || penable !== (age >= 2) || paddr !== x_addr || pwrite !== x_wr ||
                    pwdata !== x_wd || busy !== 1'b1) begin
                    errors++; $display("FAIL rnd_bus c%0d: got %b%b %h %b %h busy=%b expected 1%b %h %b %h busy=1",
                                       c, psel, penable, paddr, pwrite, pwdata, busy, age >= 2, x_addr, x_wr, x_wd);
                end
            end else if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rnd_idle c%0d: got psel=%b penable=%b busy=%b expected 0 0 0",
                                   c, psel, penable, busy);
            end
            if (act && age >= 2 && (age - 2) == nwait) begin
                pready = 1'b1; prdata = x_rd; pslverr = x_err;
                ending = 1; rsp_due = 1;
                hold_rd = x_wr ? '0 : x_rd;
                hold_err = x_err;
            end else begin
                pready = (act && age >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
                prdata = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < NR; i++) begin
                if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    ra[i] = ADDR_WIDTH'($urandom);
                    rw[i] = 1'($urandom_range(0, 1));
                    rd[i] = $urandom;
                end
                set_req(i, pend[i], rw[i], ra[i], rd[i]);
            end
            #1;
            exp_ready = '0;
            if (!act) begin
                for (int k = 1; k <= NR; k++) begin
                    int j;
                    j = (ptr + k) % NR;
                    if (pend[j]) begin
                        exp_ready[j] = 1'b1;
                        break;
                    end
                end
            end
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            for (int g = 0; g < NR; g++) begin
                if (exp_ready[g]) begin
                    act = 1; age = 0; own = g; ptr = g;
                    x_addr = ra[g]; x_wr = rw[g]; x_wd = rd[g];
                    x_rd = $urandom;
                    x_err = ($urandom_range(0, 3) == 0);
                    nwait = $urandom_range(0, 3);
                    pend[g] = 0;
                end
            end
        end
        req_valid = '0;
        pready = 1'b1;
        repeat (8) step();
        pready = 1'b0;
    endtask

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        test_reset();
        test_single_read();
        test_write_wait();
        test_round_robin();
        test_slave_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB completer port (the dual-port memory's APB slave) among NUM_REQ local requesters.
- Accepts one request at a time through a valid/ready handshake and sequences it through the IDLE/SETUP/ACCESS phases.
- Returns read data and error status to the requester that issued it.
- Adds a PREADY watchdog so a hung completer cannot stall the bus.
- All address/data widths come from apb_pkg: ADDR_WIDTH=10, DATA_WIDTH=32.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, ACCESS cycles allowed without PREADY before abort; 0 disables the watchdog.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*10 +: 10].
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i at [i*32 +: 32].
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, shared; valid with rsp_valid.
- rsp_slverr  out  1  error flag, shared; valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready, pslverr  in  1  APB completer status.
- prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Reset (async, immediate): state=IDLE; psel=penable=pwrite=0; paddr=0; pwdata=0; rsp_valid=0; rsp_rdata=0; rsp_slverr=0; timeout counter=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- A reset mid-transfer aborts silently: no rsp_valid is issued.
- FSM uses apb_state_t.
- IDLE:
  - Winner g = first requester with req_valid=1, searching from last_grant+1 upward with wrap.
  - req_ready[g]=1 combinationally, only in IDLE; all other bits 0. No valid requests -> req_ready=0.
  - On accept: latch addr/write/wdata into paddr/pwrite/pwdata; record owner=g; last_grant<=g; next state SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle; next state ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
  - pready and pslverr are sampled only in ACCESS.
  - pready=1: next cycle state=IDLE, psel=penable=0, rsp_valid[owner]=1 for one cycle.
    - rsp_rdata = prdata for reads; 0 for writes.
    - rsp_slverr = pslverr.
  - Timeout: counter increments each ACCESS cycle with pready=0. If TIMEOUT!=0 and the TIMEOUT-th ACCESS cycle ends without pready, abort: state=IDLE, psel=penable=0, rsp_valid[owner]=1, rsp_rdata=0, rsp_slverr=1. Counter clears on leaving ACCESS.
- Throughput:
  - Minimum 3 cycles per transfer: IDLE accept, SETUP, ACCESS with pready=1.
  - The rsp_valid cycle coincides with the next IDLE, which may accept the next request in that same cycle.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ transfers.
  - req_valid deasserted before being granted is ignored; no request is lost or duplicated.
- rsp_rdata and rsp_slverr hold their values until the next completion.
- busy is registered: high from SETUP through the last ACCESS cycle.

Test Plan:
- Single read: req0 valid, addr=0x155, write=0; pready=1 on the first ACCESS cycle with prdata=0xDEADBEEF -> psel is high for 2 cycles; rsp_valid=2'b01 one cycle later with rsp_rdata=0xDEADBEEF and rsp_slverr=0.
- Write with wait states: req1 write, addr=0x3FF, wdata=0xA5A5A5A5; pready held low 3 ACCESS cycles -> pwdata/paddr stable all 4 ACCESS cycles; rsp_valid=2'b10, rsp_rdata=0, rsp_slverr=0.
- Round-robin: both req_valid held high for 4 transfers -> grant order 0,1,0,1 with no gap IDLE cycles beyond the accept cycle.
- Slave error: pready=1 with pslverr=1 on a read -> rsp_slverr=1 and rsp_rdata=prdata.
- Timeout: pready never asserts, TIMEOUT=16 -> exactly 16 ACCESS cycles, then psel=0; rsp_valid to the owner with rsp_slverr=1 and rsp_rdata=0.
- Reset mid-ACCESS: assert preset during an ACCESS cycle -> psel, penable and rsp_valid are 0 immediately; after release, req0 wins first.
